// File: rtl/mouse_event_regs.sv
// AXI4-Lite register block fronting a mouse event FIFO (status, control, pop-on-read event port, scratch).
// Latency: RVALID/BVALID one cycle after the READY pulse; pushed events reach STATUS one cycle after ev_valid.
// Backpressure: responses hold until BREADY/RREADY; ev_valid has none, so events arriving when full are dropped and flagged.
module mouse_event_regs #(
  parameter int NUM_REGS    = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int EVENT_WIDTH = 24,
  parameter int ADDR_WIDTH  = $clog2(NUM_REGS) + 2
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [ADDR_WIDTH-1:0]  S_AXI_AWADDR,
  input  logic                   S_AXI_AWVALID,
  output logic                   S_AXI_AWREADY,
  input  logic [31:0]            S_AXI_WDATA,
  input  logic [3:0]             S_AXI_WSTRB,
  input  logic                   S_AXI_WVALID,
  output logic                   S_AXI_WREADY,
  output logic [1:0]             S_AXI_BRESP,
  output logic                   S_AXI_BVALID,
  input  logic                   S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]  S_AXI_ARADDR,
  input  logic                   S_AXI_ARVALID,
  output logic                   S_AXI_ARREADY,
  output logic [31:0]            S_AXI_RDATA,
  output logic [1:0]             S_AXI_RRESP,
  output logic                   S_AXI_RVALID,
  input  logic                   S_AXI_RREADY,
  input  logic                   ev_valid,
  input  logic [EVENT_WIDTH-1:0] ev_data,
  output logic                   irq
);
  localparam int IW = ADDR_WIDTH - 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                   aw_rdy_q, ar_rdy_q, bvalid_q, rvalid_q;
  logic [1:0]             bresp_q, rresp_q;
  logic [31:0]            rdata_q;
  logic                   irq_en_q, ovf_q;
  logic [31:0]            scratch [3:NUM_REGS-1];
  logic [EVENT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;

  logic [IW-1:0] aw_idx, ar_idx;
  logic          wr_hs, ar_hs, wr_err, wr_ok, ar_oor;
  logic          fifo_empty, fifo_full, pop, push_ok, ovf_set, ovf_clr, flush;
  logic [31:0]   rd_val;
  logic          rd_err;
  logic          unused_addr_lsbs;

  assign aw_idx           = S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign ar_idx           = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign unused_addr_lsbs = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_hs = aw_rdy_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign ar_hs = ar_rdy_q & S_AXI_ARVALID;

  // Writes that would put nonzero data into the read-only count field are rejected,
  // so a plain W1C of overflow (count bytes zero) is accepted with any strobe.
  assign wr_err = (int'(aw_idx) >= NUM_REGS) || (aw_idx == IW'(2)) ||
                  ((aw_idx == IW'(0)) &&
                   ((S_AXI_WSTRB[0] && (S_AXI_WDATA[7:0]  != 8'h00)) ||
                    (S_AXI_WSTRB[1] && (S_AXI_WDATA[15:8] != 8'h00))));
  assign wr_ok  = wr_hs & ~wr_err;
  assign ar_oor = int'(ar_idx) >= NUM_REGS;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign flush      = wr_ok && (aw_idx == IW'(1)) && S_AXI_WSTRB[0] && S_AXI_WDATA[1];
  assign ovf_clr    = wr_ok && (aw_idx == IW'(0)) && S_AXI_WSTRB[2] && S_AXI_WDATA[18];
  assign pop        = ar_hs && (ar_idx == IW'(2)) && !fifo_empty;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign push_ok    = ev_valid && !flush && (!fifo_full || pop);
  assign ovf_set    = ev_valid && !flush && fifo_full && !pop;

  assign S_AXI_AWREADY = aw_rdy_q;
  assign S_AXI_WREADY  = aw_rdy_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ar_rdy_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign irq           = irq_en_q & ~fifo_empty;

  // Read data mux; out-of-range reads return zero with an error response.
  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    if (ar_oor) begin
      rd_err = 1'b1;
    end else if (ar_idx == IW'(0)) begin
      rd_val = {13'b0, ovf_q, fifo_full, fifo_empty, 16'(count)};
    end else if (ar_idx == IW'(1)) begin
      rd_val = {31'b0, irq_en_q};
    end else if (ar_idx == IW'(2)) begin
      if (!fifo_empty) rd_val = 32'(fifo_mem[rd_ptr]);
    end else begin
      for (int i = 3; i < NUM_REGS; i++) begin
        if (ar_idx == IW'(i)) rd_val = scratch[i];
      end
    end
  end

  // Write channel: one-cycle READY pulse, then hold the response until BREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      aw_rdy_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~aw_rdy_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read channel: capture data at the AR handshake and hold it until RREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ar_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      ar_rdy_q <= S_AXI_ARVALID & ~rvalid_q & ~ar_rdy_q;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
        rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Control, sticky overflow and byte-enabled scratch registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 3; i < NUM_REGS; i++) scratch[i] <= '0;
    end else begin
      if (wr_ok && (aw_idx == IW'(1)) && S_AXI_WSTRB[0]) irq_en_q <= S_AXI_WDATA[0];
      // Set wins over a same-cycle clear so no overflow is ever lost.
      ovf_q <= (ovf_q & ~ovf_clr) | ovf_set;
      for (int i = 3; i < NUM_REGS; i++) begin
        if (wr_ok && (aw_idx == IW'(i))) begin
          for (int b = 0; b < 4; b++) begin
            if (S_AXI_WSTRB[b]) scratch[i][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
          end
        end
      end
    end
  end

  // FIFO pointers and occupancy; flush empties everything and discards a same-cycle push.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
    end
  end

  // Event storage; contents are only observable through the pointers, so no reset.
  always_ff @(posedge ACLK) begin
    if (push_ok) fifo_mem[wr_ptr] <= ev_data;
  end

endmodule

// File: tb/tb_mouse_event_regs.sv
// Bench for mouse_event_regs: directed register/FIFO scenarios then random traffic against a queue model.
// Latency: each AXI access spans a few cycles; outputs are sampled on the falling clock edge.
// Backpressure: BREADY/RREADY are raised once the response is seen; every wait is bounded.
module tb_mouse_event_regs;
  localparam int NR    = 8;
  localparam int DEPTH = 16;
  localparam int EW    = 24;
  localparam int AW    = 8;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [AW-1:0] S_AXI_AWADDR = '0;
  logic          S_AXI_AWVALID = 1'b0;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA = '0;
  logic [3:0]    S_AXI_WSTRB = '0;
  logic          S_AXI_WVALID = 1'b0;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY = 1'b0;
  logic [AW-1:0] S_AXI_ARADDR = '0;
  logic          S_AXI_ARVALID = 1'b0;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY = 1'b0;
  logic          ev_valid = 1'b0;
  logic [EW-1:0] ev_data = '0;
  logic          irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [EW-1:0] q[$];
  logic          ovf_m = 1'b0;
  logic          irq_en_m = 1'b0;
  logic [31:0]   scr_m [NR];

  mouse_event_regs #(.NUM_REGS(NR), .FIFO_DEPTH(DEPTH), .EVENT_WIDTH(EW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .ev_valid(ev_valid), .ev_data(ev_data), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    q.delete();
    ovf_m    = 1'b0;
    irq_en_m = 1'b0;
    for (int i = 0; i < NR; i++) scr_m[i] = '0;
  endfunction

  function automatic void model_push(input logic [EW-1:0] d);
    if (q.size() < DEPTH) q.push_back(d);
    else ovf_m = 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    int n = q.size();
    logic [31:0] s = 32'(n);
    if (n == 0)     s = s + 32'h0001_0000;
    if (n == DEPTH) s = s + 32'h0002_0000;
    if (ovf_m)      s = s + 32'h0004_0000;
    return s;
  endfunction

  function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] d,
                                             input logic [3:0] s, output logic flushed);
    int idx = int'(addr >> 2);
    flushed = 1'b0;
    if (idx >= NR || idx == 2) return 2'b10;
    if (idx == 0) begin
      if ((s[0] && d[7:0] != 8'h00) || (s[1] && d[15:8] != 8'h00)) return 2'b10;
      if (s[2] && d[18]) ovf_m = 1'b0;
    end else if (idx == 1) begin
      if (s[0]) begin
        irq_en_m = d[0];
        if (d[1]) begin
          q.delete();
          flushed = 1'b1;
        end
      end
    end else begin
      for (int b = 0; b < 4; b++) if (s[b]) scr_m[idx][8*b +: 8] = d[8*b +: 8];
    end
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] addr, output logic [1:0] resp);
    int idx = int'(addr >> 2);
    resp = 2'b00;
    if (idx >= NR) begin
      resp = 2'b10;
      return 32'h0;
    end
    if (idx == 0) return model_status();
    if (idx == 1) return {31'b0, irq_en_m};
    if (idx == 2) return (q.size() > 0) ? 32'(q.pop_front()) : 32'h0;
    return scr_m[idx];
  endfunction

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] s,
                           input logic ev_hs, input logic [EW-1:0] ev_d, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR = addr; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("aw_handshake", 32'(n < 50), 32'd1);
    chk("wready_with_awready", 32'(S_AXI_WREADY), 32'd1);
    if (ev_hs) begin ev_valid = 1'b1; ev_data = ev_d; end
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; ev_valid = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin @(negedge ACLK); n++; end
    chk("bvalid_seen", 32'(n < 50), 32'd1);
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, input logic ev_hs, input logic [EW-1:0] ev_d,
                          output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("ar_handshake", 32'(n < 50), 32'd1);
    if (ev_hs) begin ev_valid = 1'b1; ev_data = ev_d; end
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0; ev_valid = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 50) begin @(negedge ACLK); n++; end
    chk("rvalid_seen", 32'(n < 50), 32'd1);
    d = S_AXI_RDATA; resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [7:0] addr, input logic [31:0] d,
                          input logic [3:0] s, input logic ev_hs, input logic [EW-1:0] ev_d);
    logic [1:0] exp_resp, resp;
    logic fl;
    exp_resp = model_write(addr, d, s, fl);
    if (ev_hs && !fl) model_push(ev_d);
    axi_write(addr, d, s, ev_hs, ev_d, resp);
    chk({tag, "_bresp"}, 32'(resp), 32'(exp_resp));
  endtask

  task automatic do_read(input string tag, input logic [7:0] addr, input logic ev_hs,
                         input logic [EW-1:0] ev_d);
    logic [31:0] exp_d, d;
    logic [1:0]  exp_resp, resp;
    exp_d = model_read(addr, exp_resp);
    if (ev_hs) model_push(ev_d);
    axi_read(addr, ev_hs, ev_d, d, resp);
    chk({tag, "_rdata"}, d, exp_d);
    chk({tag, "_rresp"}, 32'(resp), 32'(exp_resp));
  endtask

  task automatic do_push(input logic [EW-1:0] d);
    @(negedge ACLK);
    ev_valid = 1'b1; ev_data = d;
    @(negedge ACLK);
    ev_valid = 1'b0;
    model_push(d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op;
    logic [7:0] a;
    model_reset();

    // Outputs during reset
    #12;
    chk("rst_handshake_outs", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                                   S_AXI_RVALID, irq, S_AXI_BRESP, S_AXI_RRESP}), 32'd0);
    chk("rst_rdata", S_AXI_RDATA, 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    do_read("status_after_rst", 8'h00, 1'b0, '0);

    // Byte-strobed scratch write
    do_write("scr_full", 8'h0C, 32'hFFFF_FFFF, 4'b1111, 1'b0, '0);
    do_write("scr_strb", 8'h0C, 32'hA5A5_0001, 4'b0011, 1'b0, '0);
    do_read("scr_strb_rb", 8'h0C, 1'b0, '0);

    // Three events in, three out in order, then empty read
    do_push(24'h010203); do_push(24'h040506); do_push(24'h070809);
    do_read("status_3", 8'h00, 1'b0, '0);
    do_read("ev_1", 8'h08, 1'b0, '0);
    do_read("ev_2", 8'h08, 1'b0, '0);
    do_read("ev_3", 8'h08, 1'b0, '0);
    do_read("ev_empty", 8'h08, 1'b0, '0);
    do_read("status_empty", 8'h00, 1'b0, '0);

    // Overflow, W1C, push+pop while full, set-beats-clear
    for (int i = 0; i < DEPTH + 2; i++) do_push(EW'(32'h100 + i));
    do_read("status_ovf", 8'h00, 1'b0, '0);
    do_write("ovf_w1c", 8'h00, 32'h0004_0000, 4'b0100, 1'b0, '0);
    do_read("status_w1c", 8'h00, 1'b0, '0);
    do_read("ev_pop_push_full", 8'h08, 1'b1, 24'hABCDEF);
    do_read("status_pop_push", 8'h00, 1'b0, '0);
    do_push(24'h111111);
    do_write("ovf_set_vs_clr", 8'h00, 32'h0004_0000, 4'b0100, 1'b1, 24'h222222);
    do_read("status_set_wins", 8'h00, 1'b0, '0);
    do_write("ovf_w1c2", 8'h00, 32'h0004_0000, 4'b1111, 1'b0, '0);

    // Flush, including a push on the flush edge while full
    do_write("flush_push", 8'h04, 32'h0000_0002, 4'b0001, 1'b1, 24'h333333);
    do_read("status_flush", 8'h00, 1'b0, '0);
    do_read("ctrl_after_flush", 8'h04, 1'b0, '0);

    // Error responses
    do_write("status_count_wr", 8'h00, 32'h0000_0001, 4'b0001, 1'b0, '0);
    do_write("event_wr", 8'h08, 32'h1234_5678, 4'b1111, 1'b0, '0);
    do_write("oor_wr", 8'h20, 32'hDEAD_BEEF, 4'b1111, 1'b0, '0);
    do_read("oor_rd", 8'h20, 1'b0, '0);

    // Interrupt follows irq_en and FIFO occupancy
    do_write("ctrl_irq_en", 8'h04, 32'h0000_0001, 4'b0001, 1'b0, '0);
    chk("irq_empty", 32'(irq), 32'd0);
    do_push(24'h0A0B0C);
    chk("irq_after_push", 32'(irq), 32'd1);
    do_read("ev_irq", 8'h08, 1'b0, '0);
    chk("irq_after_pop", 32'(irq), 32'd0);

    // Random traffic against the model
    for (int t = 0; t < 250; t++) begin
      op = $urandom_range(0, 7);
      case (op)
        0, 1: do_push(EW'($urandom));
        2: do_read("rnd_ev", 8'h08, 1'($urandom_range(0, 1)), EW'($urandom));
        3: do_write("rnd_scr", 8'(8'($urandom_range(3, NR - 1)) << 2), $urandom,
                    4'($urandom_range(0, 15)), 1'b0, '0);
        4: begin
          if ($urandom_range(0, 3) == 0) a = 8'(8'($urandom_range(NR, 63)) << 2);
          else a = 8'(8'($urandom_range(3, NR - 1)) << 2);
          do_read("rnd_rd", a, 1'b0, '0);
        end
        5: do_read("rnd_status", 8'h00, 1'b0, '0);
        6: do_write("rnd_w1c", 8'h00, 32'h0004_0000, 4'b0100, 1'($urandom_range(0, 1)), EW'($urandom));
        default: do_write("rnd_ctrl", 8'h04,
                          ($urandom_range(0, 7) == 0) ? 32'h3 : 32'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), 1'b0, '0);
      endcase
      chk("rnd_irq", 32'(irq), 32'(irq_en_m && (q.size() > 0)));
    end

    // Reset while a write response is pending
    do_write("pre_rst_scr", 8'h10, 32'h5A5A_5A5A, 4'b1111, 1'b0, '0);
    @(negedge ACLK);
    S_AXI_AWADDR = 8'h14; S_AXI_WDATA = 32'h1357_9BDF; S_AXI_WSTRB = 4'b1111;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    repeat (2) @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("bvalid_before_rst", 32'(S_AXI_BVALID), 32'd1);
    #1 ARESET = 1'b1;
    #1 chk("bvalid_in_rst", 32'(S_AXI_BVALID), 32'd0);
    model_reset();
    @(negedge ACLK);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    chk("bvalid_after_rst", 32'(S_AXI_BVALID), 32'd0);
    for (int i = 3; i < NR; i++) do_read("scr_after_rst", 8'(i * 4), 1'b0, '0);
    do_read("status_after_rst2", 8'h00, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mouse_event_regs.md
MOUSE_EVENT_REGS -- requirements
Module: mouse_event_regs

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 8, giving the number of 32-bit registers (minimum 4).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving the event FIFO depth (power of two, 2..256).
REQ-003 The block SHALL have parameter EVENT_WIDTH, default 24, giving the event payload width (8..32): buttons, dx and dy.
REQ-004 The block SHALL have parameter ADDR_WIDTH, default clog2(NUM_REGS)+2, giving the byte-address width.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 The block SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port ARESET, input, 1 bit: asynchronous active-high reset.
REQ-008 The block SHALL have port S_AXI_AWADDR, input, ADDR_WIDTH bits: write address.
REQ-009 The block SHALL have ports S_AXI_AWVALID (input, 1 bit) and S_AXI_AWREADY (output, 1 bit): write-address handshake.
REQ-010 The block SHALL have port S_AXI_WDATA, input, 32 bits: write data.
REQ-011 The block SHALL have port S_AXI_WSTRB, input, 4 bits: byte write enables.
REQ-012 The block SHALL have ports S_AXI_WVALID (input, 1 bit) and S_AXI_WREADY (output, 1 bit): write-data handshake.
REQ-013 The block SHALL have port S_AXI_BRESP, output, 2 bits: write response (OKAY=00, SLVERR=10).
REQ-014 The block SHALL have ports S_AXI_BVALID (output, 1 bit) and S_AXI_BREADY (input, 1 bit): write-response handshake.
REQ-015 The block SHALL have port S_AXI_ARADDR, input, ADDR_WIDTH bits: read address.
REQ-016 The block SHALL have ports S_AXI_ARVALID (input, 1 bit) and S_AXI_ARREADY (output, 1 bit): read-address handshake.
REQ-017 The block SHALL have port S_AXI_RDATA, output, 32 bits, and port S_AXI_RRESP, output, 2 bits: read data and read response.
REQ-018 The block SHALL have ports S_AXI_RVALID (output, 1 bit) and S_AXI_RREADY (input, 1 bit): read-data handshake.
REQ-019 The block SHALL have port ev_valid, input, 1 bit: one-cycle pulse meaning a mouse event is present; there is no backpressure.
REQ-020 The block SHALL have port ev_data, input, EVENT_WIDTH bits: the event payload, sampled when ev_valid=1.
REQ-021 The block SHALL have port irq, output, 1 bit: level interrupt, high when irq_en=1 and the FIFO is not empty.

Function
REQ-022 The register map SHALL be: 0x0 STATUS (RO; [15:0] count, [16] empty, [17] full, [18] overflow W1C); 0x4 CTRL ([0] irq_en RW, [1] flush, self-clearing, reads 0); 0x8 EVENT (RO, pop-on-read, data zero-extended); 0xC and above, up to NUM_REGS-1, scratch RW.
REQ-023 Write path: AWREADY and WREADY SHALL pulse high together for exactly one cycle when AWVALID=WVALID=1 and BVALID=0; the register update SHALL occur at that edge.
REQ-024 BVALID SHALL rise the cycle after the write handshake and hold until the BREADY handshake; no new write SHALL be accepted while BVALID=1.
REQ-025 Read path: ARREADY SHALL pulse for one cycle when ARVALID=1 and RVALID=0; RVALID SHALL rise on the next cycle with RDATA/RRESP stable until RREADY=1.
REQ-026 WSTRB SHALL gate each byte of scratch and CTRL writes; byte lanes with WSTRB=0 SHALL be unchanged.
REQ-027 An address with index >= NUM_REGS, or a write to STATUS[15:0] or to EVENT, SHALL return SLVERR; out-of-range reads SHALL return RDATA=0 with SLVERR; no state SHALL change.
REQ-028 An accepted EVENT read SHALL return the head entry and pop it at the AR handshake; a read of an empty FIFO SHALL return 0, OKAY, and SHALL NOT change the count.
REQ-029 ev_valid with the FIFO not full SHALL push ev_data; count SHALL update on the next cycle (one-cycle latency to STATUS).
REQ-030 ev_valid with the FIFO full SHALL drop the event and set overflow; overflow SHALL stay set until written 1.
REQ-031 A simultaneous push and pop SHALL both take effect and leave count unchanged, including when the FIFO is full (the push is accepted).
REQ-032 A simultaneous overflow set and W1C clear of overflow SHALL leave overflow set.
REQ-033 Flush SHALL empty the FIFO in one cycle; a push in the same cycle as flush SHALL be discarded without setting overflow.
REQ-034 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.

Reset
REQ-035 While ARESET=1, all READY/VALID outputs, irq, BRESP, RRESP, RDATA, registers, pointers, count and overflow SHALL be 0; STATUS SHALL read 0x0001_0000 afterwards. Reset mid-transaction SHALL abort it with no pending response.

Verification
REQ-036 Write 0xA5A5_0001 to 0xC with WSTRB=0011, after prior contents 0xFFFF_FFFF -> reads back 0xFFFF_0001, OKAY.
REQ-037 Push 3 events 0x010203, 0x040506, 0x070809 -> STATUS=0x0000_0003; three EVENT reads return them in order; a 4th read returns 0 and STATUS=0x0001_0000.
REQ-038 Push FIFO_DEPTH+2 events -> count=16, full=1, overflow=1; write 0x0004_0000 to STATUS -> overflow=0.
REQ-039 With the FIFO full, ev_valid on the same edge as an EVENT AR handshake -> count stays 16 and overflow stays 0.
REQ-040 CTRL=1 and one push -> irq=1 the next cycle; after the pop irq=0; read of 0x20 with NUM_REGS=8 -> SLVERR, 0.
REQ-041 ARESET asserted while BVALID=1 and BREADY=0 -> BVALID=0 immediately; scratch registers read 0 after release.
